load_store_unit: RTL and testbench

- Memory-access stage between the single-cycle datapath and a data memory with variable latency and a req/ready handshake.
- Takes the effective address (ALU result), store data and access type from the core.
- Aligns stores onto 32-bit memory lanes with byte enables, and extracts and sign/zero-extends load data.
- Stalls the core until the access completes, and flags misaligned/illegal accesses and bus timeouts.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/load_align.sv | 41 ++++
 rtl/load_store_unit.sv | 164 ++++++++++++++++
 tb/tb_load_store_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - Funct3 access-type encodings (RISC-V instruction bits 14:12)
//   - lsu_state_t: access FSM states
//   - f3_legal(): whether a Funct3 value is a legal load or store
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    // Unsigned variants exist only for loads.
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align: extracts the addressed byte/halfword from a 32-bit memory word
// and sign- or zero-extends it.
// Ports:
//   i_rdata  [31:0]  word returned by memory
//   i_off    [1:0]   byte offset of the access within the word
//   i_funct3 [2:0]   access type
//   o_data   [31:0]  extended load result
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_off)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        // Halfwords are aligned, so only off[1] selects the lane.
        w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_BU:   o_data = {24'b0, w_byte};
            F3_HU:   o_data = {16'b0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage between the core datapath and a
// variable-latency data memory with a req/ready handshake.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   MemRead, MemWrite, Funct3  access request and type from the core
//   ALUResult, WriteData       effective byte address and store data
//   ReadData                   extended load result (valid in DONE)
//   Stall                      freeze PC / register write while high
//   MisalignFault              pulse: misaligned or illegal access, no request
//   BusFault                   pulse in DONE when the access timed out
//   mem_req/we/addr/wdata/be   memory request, held stable until accepted
//   mem_ready, mem_rdata       memory completion and read data
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        MisalignFault,
    output logic        BusFault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    lsu_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_off;
    logic [2:0]       r_f3;
    logic             r_we;
    logic             r_mem_req;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [3:0]       r_be;
    logic [31:0]      r_rdata;
    logic             r_bus_fault;

    logic        w_access;
    logic        w_aligned;
    logic        w_valid;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic [31:0] w_load;

    assign w_access = MemRead | MemWrite;

    always_comb begin
        case (Funct3[1:0])
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = !ALUResult[0];
            2'b10:   w_aligned = (ALUResult[1:0] == 2'b00);
            default: w_aligned = 1'b0;
        endcase
    end

    assign w_valid = (MemRead ^ MemWrite) & f3_legal(Funct3, MemWrite) & w_aligned;

    // Store lane steering: narrow data is replicated so the enabled lanes
    // always carry the right bytes regardless of offset.
    always_comb begin
        w_wdata = 32'b0;
        w_be    = 4'b1111;
        if (MemWrite) begin
            case (Funct3)
                F3_B: begin
                    w_wdata = {4{WriteData[7:0]}};
                    w_be    = 4'b0001 << ALUResult[1:0];
                end
                F3_H: begin
                    w_wdata = {2{WriteData[15:0]}};
                    w_be    = ALUResult[1] ? 4'b1100 : 4'b0011;
                end
                default: w_wdata = WriteData;
            endcase
        end
    end

    load_align u_load_align (
        .i_rdata (mem_rdata),
        .i_off   (r_off),
        .i_funct3(r_f3),
        .o_data  (w_load)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_off       <= 2'b0;
            r_f3        <= 3'b0;
            r_we        <= 1'b0;
            r_mem_req   <= 1'b0;
            r_addr      <= 32'b0;
            r_wdata     <= 32'b0;
            r_be        <= 4'b0;
            r_rdata     <= 32'b0;
            r_bus_fault <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_addr    <= {ALUResult[31:2], 2'b00};
                        r_off     <= ALUResult[1:0];
                        r_f3      <= Funct3;
                        r_we      <= MemWrite;
                        r_wdata   <= w_wdata;
                        r_be      <= w_be;
                        r_mem_req <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= REQ;
                    end
                end
                REQ: begin
                    r_cnt <= r_cnt + 1'b1;
                    // Ready is tested first so it wins over a same-cycle timeout.
                    if (mem_ready) begin
                        r_mem_req <= 1'b0;
                        if (!r_we) begin
                            r_rdata <= w_load;
                        end
                        r_state <= DONE;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_mem_req   <= 1'b0;
                        r_rdata     <= 32'b0;
                        r_bus_fault <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    r_cnt       <= '0;
                    r_bus_fault <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Gated by reset so an asynchronous reset drops them before any clock edge.
    assign Stall = !reset & ((r_state == REQ) | ((r_state == IDLE) & w_valid));
    assign MisalignFault = !reset & (r_state == IDLE) & w_access & !w_valid;

    assign BusFault  = r_bus_fault;
    assign ReadData  = r_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_be    = r_be;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult, WriteData;
    logic [31:0] ReadData;
    logic        Stall, MisalignFault, BusFault;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        is_load;
        logic [31:0] rdata;
        logic        fault;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .Funct3       (Funct3),
        .ALUResult    (ALUResult),
        .WriteData    (WriteData),
        .ReadData     (ReadData),
        .Stall        (Stall),
        .MisalignFault(MisalignFault),
        .BusFault     (BusFault),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata)
    );

    function automatic logic [31:0] ext_model(input logic [31:0] d, input logic [1:0] off,
                                              input logic [2:0] f3);
        logic [31:0] v;
        v = d >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{v[7]}}, v[7:0]};
            3'b001:  return {{16{v[15]}}, v[15:0]};
            3'b100:  return {24'b0, v[7:0]};
            3'b101:  return {16'b0, v[15:0]};
            default: return d;
        endcase
    endfunction

    // One complete access; lat = REQ cycle in which mem_ready is raised (0 = never).
    // Inputs stay asserted through DONE; the caller decides what follows.
    task automatic run_access(input string name, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input int lat, input logic [31:0] rdata,
                              input logic [31:0] exp_wdata, input logic [3:0] exp_be);
        exp_t e;
        exp_t got;
        int req_cycles;
        int stall_cycles;
        int exp_req;
        logic done;
        logic [31:0] exp_addr;
        exp_addr = {addr[31:2], 2'b00};
        exp_req = (lat == 0) ? TIMEOUT : lat;
        @(negedge clk);
        MemRead = rd; MemWrite = wr; Funct3 = f3; ALUResult = addr; WriteData = wd;
        e.is_load = rd;
        e.fault = (lat == 0);
        e.rdata = (lat == 0) ? 32'h0 : ext_model(rdata, addr[1:0], f3);
        sb_q.push_back(e);
        #1;
        checks++;
        if ({Stall, mem_req, MisalignFault} !== 3'b100) begin
            errors++;
            $display("FAIL %s idle: stall/req/mis=%b required 100", name,
                     {Stall, mem_req, MisalignFault});
        end
        stall_cycles = 1;
        req_cycles = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            if (!Stall && !mem_req) begin
                done = 1'b1;
                got = sb_q.pop_front();
                checks++;
                if (BusFault !== got.fault) begin
                    errors++;
                    $display("FAIL %s busfault: got %b required %b", name, BusFault, got.fault);
                end
                if (got.is_load) begin
                    checks++;
                    if (ReadData !== got.rdata) begin
                        errors++;
                        $display("FAIL %s rdata: got %h required %h", name, ReadData, got.rdata);
                    end
                end
                checks++;
                if (req_cycles != exp_req || stall_cycles != exp_req + 1) begin
                    errors++;
                    $display("FAIL %s latency: req %0d stall %0d required %0d/%0d", name,
                             req_cycles, stall_cycles, exp_req, exp_req + 1);
                end
            end else begin
                req_cycles++;
                if (Stall) stall_cycles++;
                checks++;
                if ({mem_req, Stall, mem_we, mem_be, mem_addr} !==
                    {1'b1, 1'b1, wr, exp_be, exp_addr}) begin
                    errors++;
                    $display("FAIL %s req: req/stall/we=%b be=%b addr=%h required 11%b %b %h",
                             name, {mem_req, Stall, mem_we}, mem_be, mem_addr, wr, exp_be,
                             exp_addr);
                end
                if (wr) begin
                    checks++;
                    if (mem_wdata !== exp_wdata) begin
                        errors++;
                        $display("FAIL %s wdata: got %h required %h", name, mem_wdata, exp_wdata);
                    end
                end
                if (req_cycles == lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = rdata;
                end
                if (req_cycles > TIMEOUT + 4) begin
                    errors++;
                    $display("FAIL %s no DONE within bound: got %0d cycles required %0d", name,
                             req_cycles, exp_req);
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic go_idle(input string name);
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b0;
        #1;
        checks++;
        if ({Stall, mem_req, BusFault, MisalignFault} !== 4'b0000) begin
            errors++;
            $display("FAIL %s idle: stall/req/bus/mis=%b required 0000", name,
                     {Stall, mem_req, BusFault, MisalignFault});
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({ReadData, mem_addr, mem_wdata, mem_be, mem_req, mem_we, Stall, MisalignFault,
             BusFault} !== 105'b0) begin
            errors++;
            $display("FAIL reset: rdata=%h addr=%h wdata=%h be=%b req=%b we=%b required 0",
                     ReadData, mem_addr, mem_wdata, mem_be, mem_req, mem_we);
        end
    endtask

    task automatic test_sw();
        run_access("sw", 1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 3, 32'h0,
                   32'hDEADBEEF, 4'b1111);
        go_idle("sw");
    endtask

    task automatic test_loads();
        run_access("lb", 1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 2, 32'h80FF1234, 32'h0, 4'b1111);
        go_idle("lb");
        run_access("lbu", 1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF1234, 32'h0, 4'b1111);
        go_idle("lbu");
        run_access("lh", 1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 2, 32'h8001ABCD, 32'h0, 4'b1111);
        go_idle("lh");
        run_access("lhu", 1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 1, 32'h8001ABCD, 32'h0, 4'b1111);
        go_idle("lhu");
    endtask

    task automatic test_stores();
        run_access("sh", 1'b0, 1'b1, 3'b001, 32'h102, 32'h0000BEEF, 1, 32'h0,
                   32'hBEEFBEEF, 4'b1100);
        go_idle("sh");
        run_access("sb", 1'b0, 1'b1, 3'b000, 32'h101, 32'h123456A5, 2, 32'h0,
                   32'hA5A5A5A5, 4'b0010);
        go_idle("sb");
    endtask

    task automatic test_misalign();
        logic [5:0] cases [4];
        cases[0] = {1'b1, 1'b0, 1'b0, 3'b010};  // lw @0x102
        cases[1] = {1'b1, 1'b1, 1'b0, 3'b010};  // both asserted
        cases[2] = {1'b1, 1'b0, 1'b1, 3'b001};  // lh @0x101
        cases[3] = {1'b0, 1'b1, 1'b0, 3'b100};  // illegal store type
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            MemRead = cases[i][5]; MemWrite = cases[i][4]; Funct3 = cases[i][2:0];
            ALUResult = cases[i][3] ? 32'h101 : (i == 3 ? 32'h100 : 32'h102);
            #1;
            checks++;
            if ({MisalignFault, Stall, mem_req} !== 3'b100) begin
                errors++;
                $display("FAIL misalign %0d: mis/stall/req=%b required 100", i,
                         {MisalignFault, Stall, mem_req});
            end
            go_idle("misalign");
        end
    endtask

    task automatic test_timeout();
        run_access("timeout", 1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 0, 32'h0, 32'h0, 4'b1111);
        go_idle("timeout");
        // Ready in the final allowed cycle must win over the timeout.
        run_access("ready_at_limit", 1'b1, 1'b0, 3'b010, 32'h204, 32'h0, TIMEOUT,
                   32'h12345678, 32'h0, 4'b1111);
        go_idle("ready_at_limit");
    endtask

    task automatic test_back_to_back();
        run_access("b2b_sw", 1'b0, 1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 1, 32'h0,
                   32'hCAFEF00D, 4'b1111);
        run_access("b2b_lw", 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 2, 32'hCAFEF00D, 32'h0, 4'b1111);
        go_idle("b2b");
    endtask

    task automatic test_reset_mid_req();
        @(negedge clk);
        MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h400;
        @(negedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_req setup: mem_req got %b required 1", mem_req);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({mem_req, Stall} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_req drop: req/stall=%b required 00", {mem_req, Stall});
        end
        @(negedge clk);
        MemRead = 1'b0;
        reset = 1'b0;
        #1;
        test_reset();
    endtask

    initial begin
        reset = 1'b1;
        MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b0;
        ALUResult = 32'h0; WriteData = 32'h0;
        mem_ready = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b0;
        test_sw();
        test_loads();
        test_stores();
        test_misalign();
        test_timeout();
        test_back_to_back();
        test_reset_mid_req();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard residue: got %0d entries required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
